// File: rtl/lcd_pkg.sv
// Shared LCD definitions: word layout, panel commands, RGB565 colours, and the
// SPI transmitter state encoding.
package lcd_pkg;
  localparam int DC_BIT = 8;
  localparam int WORD_W = 9;

  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } spi_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lcd_spi_tx_if.sv
// Upstream word stream into the LCD SPI transmitter: level request, 9-bit word,
// per-byte completion pulse and busy.
interface lcd_spi_tx_if;
  import lcd_pkg::*;

  logic              en_write;
  logic [WORD_W-1:0] data;
  logic              wr_done;
  logic              busy;

  modport master (output en_write, data, input wr_done, busy);
  modport slave  (input en_write, data, output wr_done, busy);
endinterface

// File: rtl/lcd_spi_tick.sv
// SCLK half-period divider: one-cycle tick every SCLK_DIV enabled cycles,
// restarted from zero on clr or whenever disabled.
module lcd_spi_tick
  import lcd_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int            CW   = cnt_w(SCLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                cnt <= '0;
    else if (clr || !en || tick)   cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/lcd_spi_tx.sv
// Mode-0 SPI byte transmitter for the LCD panel; paces a level-held burst of
// 9-bit {dc, byte} words and pulses wr_done once per byte.
module lcd_spi_tx
  import lcd_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter int CS_SETUP = 1,
  parameter int GAP      = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  lcd_spi_tx_if.slave  up,
  output logic         lcd_cs_n,
  output logic         lcd_dc,
  output logic         lcd_sclk,
  output logic         lcd_mosi
);
  localparam int            TMR_MAX    = (CS_SETUP > GAP) ? CS_SETUP : GAP;
  localparam int            TW         = cnt_w(TMR_MAX);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);

  spi_state_e    state, nxt;
  logic [TW-1:0] tmr;
  logic [3:0]    tog_cnt;
  logic [6:0]    shift_reg;   // bits still to send after the one on lcd_mosi
  logic          tick, load, cs_release;
  logic          wr_done_q, busy_q;

  assign up.wr_done = wr_done_q;
  assign up.busy    = busy_q;

  lcd_spi_tick #(.SCLK_DIV(SCLK_DIV)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (load),
    .en        (state == ST_SHIFT),
    .tick      (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt        = state;
    load       = 1'b0;
    cs_release = 1'b0;
    case (state)
      ST_IDLE:  if (up.en_write) begin load = 1'b1; nxt = ST_SETUP; end
      ST_SETUP: if (tmr == SETUP_LAST) nxt = ST_SHIFT;
      ST_SHIFT: if (tick && tog_cnt == 4'd15) nxt = ST_DONE;
      ST_DONE:  nxt = ST_GAP;
      ST_GAP: begin
        // Back-to-back bytes keep CS low and skip the setup delay.
        if (tmr == GAP_LAST) begin
          if (up.en_write) begin load = 1'b1; nxt = ST_SHIFT; end
          else begin cs_release = 1'b1; nxt = ST_IDLE; end
        end
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                tmr <= '0;
    else if (state != nxt)                         tmr <= '0;
    else if (state == ST_SETUP || state == ST_GAP) tmr <= tmr + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_reg <= '0;
      tog_cnt   <= '0;
      lcd_cs_n  <= 1'b1;
      lcd_dc    <= 1'b0;
      lcd_sclk  <= 1'b0;
      lcd_mosi  <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (load) begin
        shift_reg <= up.data[6:0];
        lcd_dc    <= up.data[DC_BIT];
        lcd_mosi  <= up.data[7];
        lcd_cs_n  <= 1'b0;
        tog_cnt   <= '0;
      end else if (tick) begin
        lcd_sclk <= ~lcd_sclk;
        tog_cnt  <= tog_cnt + 1'b1;
        // Odd count = falling toggle; the last one leaves MOSI as is.
        if (tog_cnt[0] && tog_cnt != 4'd15) begin
          lcd_mosi  <= shift_reg[6];
          shift_reg <= {shift_reg[5:0], 1'b0};
        end
      end
      if (cs_release) lcd_cs_n <= 1'b1;
      wr_done_q <= (nxt == ST_DONE);
      busy_q    <= (nxt != ST_IDLE);
    end
  end
endmodule
